uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop synchronized line, 16x-oversampled framing FSM, show-ahead receive FIFO.
// A good word lands in the FIFO one clock after its last stop sample; when the FIFO is full it is dropped and overrun is flagged.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk210_p,
  input  logic                          reset_n_p,
  input  logic                          rx_p,
  input  logic                          baud_16_x_p,
  input  logic                          fifo_rx_rd_en_p,
  output logic [DATA_BITS-1:0]          fifo_rx_dout_p,
  output logic                          fifo_rx_empty_p,
  output logic                          fifo_rx_full_p,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_rx_data_count_p,
  input  logic                          err_clear_p,
  output logic                          frame_err_p,
  output logic                          parity_err_p,
  output logic                          overrun_p
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP = (STOP_BITS == 2);
  localparam logic        ODD_PAR   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  logic                 r_rx_meta, r_rx_sync;
  state_t               r_state;
  logic [3:0]           r_tick;
  logic [3:0]           r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_bad;
  logic                 r_wr_vld;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic w_tick_end, w_empty, w_full, w_rd, w_wr;

  assign w_tick_end = (r_tick == 4'd15);

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_p;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      r_state      <= IDLE;
      r_tick       <= '0;
      r_bit        <= '0;
      r_stop       <= 1'b0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_bad        <= 1'b0;
      r_wr_vld     <= 1'b0;
      frame_err_p  <= 1'b0;
      parity_err_p <= 1'b0;
    end else begin
      r_wr_vld <= 1'b0;
      // Clear first so a same-cycle set below takes priority.
      if (err_clear_p) begin
        frame_err_p  <= 1'b0;
        parity_err_p <= 1'b0;
      end
      if (baud_16_x_p) begin
        case (r_state)
          IDLE: begin
            if (!r_rx_sync) begin
              r_state <= START;
              r_tick  <= '0;
            end
          end
          START: begin
            if (r_tick == 4'd7) begin
              if (r_rx_sync) begin
                r_state <= IDLE;
              end else begin
                r_state <= DATA;
                r_tick  <= '0;
                r_bit   <= '0;
                r_par   <= 1'b0;
                r_bad   <= 1'b0;
              end
            end else begin
              r_tick <= r_tick + 4'd1;
            end
          end
          DATA: begin
            if (w_tick_end) begin
              r_tick  <= '0;
              r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
              r_par   <= r_par ^ r_rx_sync;
              if (r_bit == LAST_BIT) begin
                r_state <= (PARITY_MODE != 0) ? PARITY : STOP;
                r_stop  <= 1'b0;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end else begin
              r_tick <= r_tick + 4'd1;
            end
          end
          PARITY: begin
            if (w_tick_end) begin
              r_tick  <= '0;
              r_state <= STOP;
              if (r_rx_sync != (r_par ^ ODD_PAR)) begin
                r_bad        <= 1'b1;
                parity_err_p <= 1'b1;
              end
            end else begin
              r_tick <= r_tick + 4'd1;
            end
          end
          STOP: begin
            if (w_tick_end) begin
              r_tick <= '0;
              if (!r_rx_sync) begin
                frame_err_p <= 1'b1;
                r_state     <= BREAK_WAIT;
              end else if (r_stop == LAST_STOP) begin
                r_state  <= IDLE;
                r_wr_vld <= !r_bad;
              end else begin
                r_stop <= 1'b1;
              end
            end else begin
              r_tick <= r_tick + 4'd1;
            end
          end
          BREAK_WAIT: begin
            if (r_rx_sync) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_rd    = fifo_rx_rd_en_p && !w_empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still succeeds.
  assign w_wr    = r_wr_vld && (!w_full || w_rd);

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      overrun_p <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (err_clear_p) overrun_p <= 1'b0;
      if (r_wr_vld && !w_wr) overrun_p <= 1'b1;
    end
  end

  always_ff @(posedge clk210_p) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  assign fifo_rx_dout_p       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_rx_empty_p      = w_empty;
  assign fifo_rx_full_p       = w_full;
  assign fifo_rx_data_count_p = r_count;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1/depth-16 instance plus an 8E2/depth-4 instance, checked against a queue model.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic baud  = 1'b0;
  int   div   = 0;

  always @(negedge clk) begin
    div  = (div + 1) % 4;
    baud = (div == 0);
  end

  logic       rx0 = 1'b1, rd0 = 1'b0, clr0 = 1'b0;
  logic [7:0] dout0;
  logic       empty0, full0, ferr0, perr0, ovr0;
  logic [4:0] cnt0;

  logic       rx1 = 1'b1, rd1 = 1'b0, clr1 = 1'b0;
  logic [7:0] dout1;
  logic       empty1, full1, ferr1, perr1, ovr1;
  logic [2:0] cnt1;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk210_p(clk), .reset_n_p(rst_n), .rx_p(rx0), .baud_16_x_p(baud),
    .fifo_rx_rd_en_p(rd0), .fifo_rx_dout_p(dout0), .fifo_rx_empty_p(empty0),
    .fifo_rx_full_p(full0), .fifo_rx_data_count_p(cnt0), .err_clear_p(clr0),
    .frame_err_p(ferr0), .parity_err_p(perr0), .overrun_p(ovr0));

  uart_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_p (
    .clk210_p(clk), .reset_n_p(rst_n), .rx_p(rx1), .baud_16_x_p(baud),
    .fifo_rx_rd_en_p(rd1), .fifo_rx_dout_p(dout1), .fifo_rx_empty_p(empty1),
    .fifo_rx_full_p(full1), .fifo_rx_data_count_p(cnt1), .err_clear_p(clr1),
    .frame_err_p(ferr1), .parity_err_p(perr1), .overrun_p(ovr1));

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the 8N1 instance: received words in order, sticky flags.
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  logic [7:0] junk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v; else rx1 = v;
  endtask

  // One bit lasts 16 ticks = 64 clocks; line is left idle-high afterwards.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit with_par,
                            input bit par_flip, input logic [1:0] stop_v, input int nstop);
    set_rx(sel, 1'b0); wait_clk(64);
    for (int i = 0; i < 8; i++) begin set_rx(sel, d[i]); wait_clk(64); end
    if (with_par) begin set_rx(sel, (^d) ^ par_flip); wait_clk(64); end
    for (int i = 0; i < nstop; i++) begin set_rx(sel, stop_v[i]); wait_clk(64); end
    set_rx(sel, 1'b1); wait_clk(32);
  endtask

  task automatic model_rx(input logic [7:0] d, input bit stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (q.size() == 16) m_ovr = 1'b1;
    else q.push_back(d);
  endtask

  task automatic pop0();
    rd0 = 1'b1; wait_clk(1); rd0 = 1'b0;
    if (q.size() > 0) junk = q.pop_front();
  endtask

  task automatic clear0();
    clr0 = 1'b1; wait_clk(1); clr0 = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wait_clk(3);
    n_vec++; if (empty0 !== 1'b1 || full0 !== 1'b0 || cnt0 !== 5'd0) begin n_err++; $display("FAIL reset_fifo0: empty=%b full=%b cnt=%0d, need 1 0 0", empty0, full0, cnt0); end
    n_vec++; if (dout0 !== 8'h00) begin n_err++; $display("FAIL reset_dout0: got %h need 00", dout0); end
    n_vec++; if ({ferr0, perr0, ovr0} !== 3'b000) begin n_err++; $display("FAIL reset_flags0: got %b need 000", {ferr0, perr0, ovr0}); end
    n_vec++; if (empty1 !== 1'b1 || full1 !== 1'b0 || cnt1 !== 3'd0 || dout1 !== 8'h00 || {ferr1, perr1, ovr1} !== 3'b000) begin
      n_err++; $display("FAIL reset_dut_p: empty=%b full=%b cnt=%0d dout=%h flags=%b", empty1, full1, cnt1, dout1, {ferr1, perr1, ovr1}); end
    rst_n = 1'b1; wait_clk(8);
  endtask

  task automatic test_single();
    send_frame(0, 8'hA5, 0, 0, 2'b11, 1); model_rx(8'hA5, 1);
    n_vec++; if (dout0 !== 8'hA5) begin n_err++; $display("FAIL single_dout: got %h need a5", dout0); end
    n_vec++; if (cnt0 !== 5'd1 || empty0 !== 1'b0) begin n_err++; $display("FAIL single_cnt: cnt=%0d empty=%b, need 1 0", cnt0, empty0); end
    n_vec++; if ({ferr0, perr0, ovr0} !== 3'b000) begin n_err++; $display("FAIL single_flags: got %b need 000", {ferr0, perr0, ovr0}); end
    pop0();
    n_vec++; if (empty0 !== 1'b1 || cnt0 !== 5'd0) begin n_err++; $display("FAIL single_pop: empty=%b cnt=%0d, need 1 0", empty0, cnt0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin send_frame(0, 8'hA0 + 8'(i), 0, 0, 2'b11, 1); model_rx(8'hA0 + 8'(i), 1); end
    n_vec++; if (cnt0 !== 5'd5) begin n_err++; $display("FAIL b2b_cnt: got %0d need 5", cnt0); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (dout0 !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL b2b_dout%0d: got %h need %h", i, dout0, 8'hA0 + 8'(i)); end
      pop0();
    end
    n_vec++; if (empty0 !== 1'b1 || cnt0 !== 5'd0) begin n_err++; $display("FAIL b2b_drain: empty=%b cnt=%0d, need 1 0", empty0, cnt0); end
  endtask

  task automatic test_glitch();
    rx0 = 1'b0; wait_clk(16); rx0 = 1'b1; wait_clk(128);
    n_vec++; if (cnt0 !== 5'd0 || {ferr0, perr0, ovr0} !== 3'b000) begin n_err++; $display("FAIL glitch: cnt=%0d flags=%b, need 0 000", cnt0, {ferr0, perr0, ovr0}); end
    send_frame(0, 8'h5A, 0, 0, 2'b11, 1); model_rx(8'h5A, 1);
    n_vec++; if (dout0 !== 8'h5A || cnt0 !== 5'd1) begin n_err++; $display("FAIL glitch_after: dout=%h cnt=%0d, need 5a 1", dout0, cnt0); end
    pop0();
  endtask

  task automatic test_frame_err();
    send_frame(0, 8'h55, 0, 0, 2'b00, 1); model_rx(8'h55, 0);
    n_vec++; if (ferr0 !== 1'b1 || cnt0 !== 5'd0) begin n_err++; $display("FAIL ferr_set: ferr=%b cnt=%0d, need 1 0", ferr0, cnt0); end
    wait_clk(64);
    send_frame(0, 8'h3C, 0, 0, 2'b11, 1); model_rx(8'h3C, 1);
    n_vec++; if (dout0 !== 8'h3C || cnt0 !== 5'd1) begin n_err++; $display("FAIL ferr_next: dout=%h cnt=%0d, need 3c 1", dout0, cnt0); end
    n_vec++; if (ferr0 !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b need 1", ferr0); end
    clear0();
    n_vec++; if (ferr0 !== 1'b0) begin n_err++; $display("FAIL ferr_clear: got %b need 0", ferr0); end
    pop0();
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 0; i < 17; i++) begin d = 8'($urandom); send_frame(0, d, 0, 0, 2'b11, 1); model_rx(d, 1); end
    n_vec++; if (full0 !== 1'b1 || cnt0 !== 5'd16) begin n_err++; $display("FAIL ovr_full: full=%b cnt=%0d, need 1 16", full0, cnt0); end
    n_vec++; if (ovr0 !== m_ovr) begin n_err++; $display("FAIL ovr_flag: got %b need %b", ovr0, m_ovr); end
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (dout0 !== q[0]) begin n_err++; $display("FAIL ovr_dout%0d: got %h need %h", i, dout0, q[0]); end
      pop0();
    end
    n_vec++; if (empty0 !== 1'b1 || cnt0 !== 5'd0) begin n_err++; $display("FAIL ovr_drain: empty=%b cnt=%0d, need 1 0", empty0, cnt0); end
    clear0();
    n_vec++; if (ovr0 !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b need 0", ovr0); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit ok;
    int np;
    for (int it = 0; it < 16; it++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(0, d, 0, 0, ok ? 2'b11 : 2'b00, 1); model_rx(d, ok);
      if (!ok) wait_clk(64);
      n_vec++; if (cnt0 !== 5'(q.size()) || ferr0 !== m_ferr || ovr0 !== m_ovr) begin
        n_err++; $display("FAIL rand_state%0d: cnt=%0d ferr=%b ovr=%b, need %0d %b %b", it, cnt0, ferr0, ovr0, q.size(), m_ferr, m_ovr); end
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) begin
        if (q.size() > 0) begin
          n_vec++; if (dout0 !== q[0]) begin n_err++; $display("FAIL rand_dout%0d: got %h need %h", it, dout0, q[0]); end
        end
        pop0();
      end
    end
    while (q.size() > 0) pop0();
    clear0();
  endtask

  task automatic test_empty_pop();
    for (int i = 0; i < 3; i++) pop0();
    n_vec++; if (cnt0 !== 5'd0 || empty0 !== 1'b1) begin n_err++; $display("FAIL empty_pop: cnt=%0d empty=%b, need 0 1", cnt0, empty0); end
    send_frame(0, 8'h81, 0, 0, 2'b11, 1); model_rx(8'h81, 1);
    n_vec++; if (cnt0 !== 5'd1 || dout0 !== 8'h81) begin n_err++; $display("FAIL empty_pop_after: cnt=%0d dout=%h, need 1 81", cnt0, dout0); end
  endtask

  task automatic test_parity();
    send_frame(1, 8'h03, 1, 1, 2'b11, 2);
    n_vec++; if (perr1 !== 1'b1 || empty1 !== 1'b1) begin n_err++; $display("FAIL par_err: perr=%b empty=%b, need 1 1", perr1, empty1); end
    clr1 = 1'b1; wait_clk(1); clr1 = 1'b0;
    n_vec++; if (perr1 !== 1'b0) begin n_err++; $display("FAIL par_clear: got %b need 0", perr1); end
    send_frame(1, 8'h03, 1, 0, 2'b11, 2);
    n_vec++; if (dout1 !== 8'h03 || cnt1 !== 3'd1 || perr1 !== 1'b0) begin n_err++; $display("FAIL par_good: dout=%h cnt=%0d perr=%b, need 03 1 0", dout1, cnt1, perr1); end
    send_frame(1, 8'h07, 1, 0, 2'b01, 2);
    wait_clk(64);
    n_vec++; if (ferr1 !== 1'b1 || cnt1 !== 3'd1) begin n_err++; $display("FAIL par_stop2: ferr=%b cnt=%0d, need 1 1", ferr1, cnt1); end
    send_frame(1, 8'hE9, 1, 0, 2'b11, 2);
    n_vec++; if (cnt1 !== 3'd2 || dout1 !== 8'h03) begin n_err++; $display("FAIL par_second: cnt=%0d dout=%h, need 2 03", cnt1, dout1); end
    rd1 = 1'b1; wait_clk(1); rd1 = 1'b0;
    n_vec++; if (dout1 !== 8'hE9 || cnt1 !== 3'd1) begin n_err++; $display("FAIL par_pop: dout=%h cnt=%0d, need e9 1", dout1, cnt1); end
  endtask

  task automatic test_reset_midframe();
    rx0 = 1'b0; wait_clk(64);
    rx0 = 1'b1; wait_clk(64);
    rx0 = 1'b0; wait_clk(96);
    rst_n = 1'b0; wait_clk(2);
    q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    n_vec++; if (cnt0 !== 5'd0 || empty0 !== 1'b1 || dout0 !== 8'h00 || {ferr0, perr0, ovr0} !== 3'b000) begin
      n_err++; $display("FAIL mid_reset: cnt=%0d empty=%b dout=%h flags=%b", cnt0, empty0, dout0, {ferr0, perr0, ovr0}); end
    rx0 = 1'b1; wait_clk(4); rst_n = 1'b1; wait_clk(64);
    send_frame(0, 8'hC3, 0, 0, 2'b11, 1); model_rx(8'hC3, 1);
    n_vec++; if (dout0 !== 8'hC3 || cnt0 !== 5'd1 || ferr0 !== 1'b0) begin n_err++; $display("FAIL mid_after: dout=%h cnt=%0d ferr=%b, need c3 1 0", dout0, cnt0, ferr0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_random();
    test_empty_pop();
    test_parity();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
